newspaper_vendor: RTL and testbench
===================================

Name: newspaper_vendor

Overview:
- Coin-operated newspaper vending controller; a paper costs 25 cents.
- Accepts one nickel, dime or quarter per clock, accumulates credit, and pulses a release once credit reaches 25.
- Returns overpayment as coin-return pulses in the same cycle as the release.
- Top-level control FSM between the coin-detector front end and the release/change solenoid drivers.

Parameters:
- none: price (25 cents) and coin values (5/10/25) are fixed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- R  output  1  release newspaper; one-cycle pulse.
- N1  output  1  return one nickel; one-cycle pulse.
- D1  output  1  return one dime; one-cycle pulse.
- D2  output  1  return two dimes; one-cycle pulse.
- Q  input  1  quarter inserted this cycle.
- D  input  1  dime inserted this cycle.
- N  input  1  nickel inserted this cycle.
- Positional port order is R, N1, D1, D2, Q, D, N, clk, reset. Existing instantiations connect by position, so reset is appended last.

Behaviour:
- Credit states: S0, S5, S10, S15, S20 (credit in cents). State encoding is free; 3 bits is sufficient.
- Reset (synchronous, active-high):
  - On the next rising edge, state = S0 and R, N1, D1, D2 = 0.
  - Reset overrides any coin in the same cycle; that coin is discarded.
- Coin sampling:
  - Inputs are sampled on each rising edge.
  - Exactly one of N/D/Q high = one valid coin of 5/10/25 cents.
  - All low = idle: state held, outputs 0.
  - More than one high = invalid: the cycle is ignored, state held, outputs 0.
- Registered outputs: all outputs come from flops. They change one clock after the edge that samples the coin (1-cycle latency) and are 0 in every cycle without a completing coin.
- Transition rule, with sum = credit + coin value:
  - sum < 25: next state = S(sum); all outputs 0.
  - sum >= 25: next state = S0; R = 1 for one cycle; change = sum - 25 (0, 5, 10, 15 or 20).
- Change encoding, asserted in the same cycle as R:
  - 0: none.
  - 5: N1.
  - 10: D1.
  - 15: D1 and N1.
  - 20: D2 only (D1 = 0).
- Maximum sum is 20 + 25 = 45, so change never exceeds 20.
- D1 and D2 are never high together. N1 is never high together with D2.
- A coin arriving in the cycle after a sale starts fresh from S0. Back-to-back sales are supported: quarter, quarter gives R on two consecutive cycles.
- No further coins are accepted beyond the completing coin, and no refund-without-purchase function exists.

Test Plan:
- Reset, then D, idle, Q -> one cycle after Q is sampled: R=1, D1=1, N1=0, D2=0; next cycle all 0, state S0.
- N, idle, D, idle, N, idle, N (total 25) -> R=1 with N1=D1=D2=0, exactly once; no outputs before the last coin.
- N, D (credit 15), then Q -> R=1, D1=1, N1=1, D2=0.
- D, D (credit 20), then Q -> R=1, D2=1, D1=0, N1=0; then Q immediately -> R=1 again with no change.
- N and D high together in the same cycle, then Q -> multi-coin cycle ignored; Q alone gives R=1 with no change.
- D, D, then reset asserted together with Q -> outputs stay 0, state S0; subsequent Q alone -> R=1, no change.

Source files
------------

// File: rtl/newspaper_vendor.sv
// newspaper_vendor: 25-cent paper vending FSM with release and change pulses
module newspaper_vendor (
  output logic R,
  output logic N1,
  output logic D1,
  output logic D2,
  input  logic Q,
  input  logic D,
  input  logic N,
  input  logic clk,
  input  logic reset
);
  typedef enum logic [2:0] {S0, S5, S10, S15, S20} state_t;
  state_t state, state_nxt;
  logic one, rel;
  logic [5:0] val, sum, chg;
  always_comb begin
    one = {Q, D, N} inside {3'b001, 3'b010, 3'b100};
    val = Q ? 6'd25 : D ? 6'd10 : 6'd5;
    sum = 6'(state) * 6'd5 + val;
    state_nxt = state;
    rel = 1'b0;
    chg = 6'd0;
    if (one) begin
      rel = sum >= 6'd25;
      chg = rel ? sum - 6'd25 : 6'd0;
      state_nxt = rel ? S0 : state_t'(3'(sum / 6'd5));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      {R, N1, D1, D2} <= 4'b0000;
    end else begin
      state <= state_nxt;
      R <= rel;
      N1 <= chg == 6'd5 || chg == 6'd15;
      D1 <= chg == 6'd10 || chg == 6'd15;
      D2 <= chg == 6'd20;
    end
  end
endmodule

// File: tb/tb_newspaper_vendor.sv
// tb_newspaper_vendor: random and directed checks against a credit-counting model
module tb_newspaper_vendor;
  logic clk = 0, reset = 0, Q = 0, D = 0, N = 0;
  logic R, N1, D1, D2;
  logic eR = 0, eN1 = 0, eD1 = 0, eD2 = 0, en = 0;
  int credit = 0, checks = 0, failures = 0;
  newspaper_vendor dut (.R(R), .N1(N1), .D1(D1), .D2(D2), .Q(Q), .D(D), .N(N), .clk(clk), .reset(reset));
  always #5 clk = ~clk;
  always @(negedge clk) if (en) begin
    checks++;
    if ({R, N1, D1, D2} !== {eR, eN1, eD1, eD2}) begin
      failures++;
      $display("FAIL model t=%0t got R/N1/D1/D2=%b exp=%b", $time, {R, N1, D1, D2}, {eR, eN1, eD1, eD2});
    end
  end
  task automatic step(input logic q, d, n, r);
    int v, s, change;
    Q = q; D = d; N = n; reset = r;
    @(posedge clk);
    change = 0;
    eR = 0;
    if (r) credit = 0;
    else if (int'(q) + int'(d) + int'(n) == 1) begin
      v = q ? 25 : d ? 10 : 5;
      s = credit + v;
      if (s >= 25) begin
        eR = 1;
        change = s - 25;
        credit = 0;
      end else credit = s;
    end
    eN1 = change % 10 == 5;
    eD1 = change == 10 || change == 15;
    eD2 = change == 20;
    #1;
  endtask
  task automatic lit(input string name, input logic [3:0] exp);
    checks++;
    if ({R, N1, D1, D2} !== exp) begin
      failures++;
      $display("FAIL %s got R/N1/D1/D2=%b exp=%b", name, {R, N1, D1, D2}, exp);
    end
  endtask
  initial begin
    logic [2:0] c;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    en = 1;
    lit("reset", 4'b0000);
    step(0, 1, 0, 0); lit("dime_only", 4'b0000);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); lit("d_q", 4'b1010);
    step(0, 0, 0, 0); lit("d_q_after", 4'b0000);
    step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0); lit("n_d_n_pre", 4'b0000);
    step(0, 0, 1, 0); lit("exact25", 4'b1000);
    step(0, 0, 0, 0); lit("exact25_after", 4'b0000);
    step(0, 0, 1, 0); step(0, 1, 0, 0); lit("credit15", 4'b0000);
    step(1, 0, 0, 0); lit("c15_q", 4'b1110);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0); lit("c20_q", 4'b1001);
    step(1, 0, 0, 0); lit("back_to_back", 4'b1000);
    step(0, 1, 1, 0); lit("multi_coin", 4'b0000);
    step(1, 0, 0, 0); lit("after_multi", 4'b1000);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 1); lit("reset_q", 4'b0000);
    step(1, 0, 0, 0); lit("post_reset_q", 4'b1000);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: c = 3'b000;
        1, 4: c = 3'b001;
        2, 5: c = 3'b010;
        3, 6: c = 3'b100;
        default: c = 3'($urandom);
      endcase
      step(c[2], c[1], c[0], $urandom_range(0, 49) == 0);
    end
    en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
